// File: rtl/branch_redirect_pkg.sv
// branch_redirect_pkg: opcodes, FSM state encoding and branch decode shared by the redirect unit
package branch_redirect_pkg;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } state_t;
  function automatic logic is_branch(input logic [4:0] op);
    return op[4:2] == OP_BEQZ[4:2];
  endfunction
endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: sign-extends imm8 and adds it to pc_plus2, wrapping silently
module branch_target_calc #(
  parameter int PC_WIDTH = 16
) (
  input  logic [PC_WIDTH-1:0] pc_plus2,
  input  logic [7:0]          imm8,
  output logic [PC_WIDTH-1:0] target
);
  assign target = pc_plus2 + {{(PC_WIDTH-8){imm8[7]}}, imm8};
endmodule

// File: rtl/branch_redirect.sv
// branch_redirect: registered PC redirect plus multi-cycle IF/ID and ID/EX squash for taken branches.
// Optional BRANCH_REDIRECT_STATS_EN adds saturating br_count/taken_count outputs.
module branch_redirect
  import branch_redirect_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic                stall,
  input  logic [4:0]          opcode,
  input  logic [PC_WIDTH-1:0] pc_plus2,
  input  logic [7:0]          imm8,
  input  logic                taken,
  output logic                redirect,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                busy
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [15:0]         br_count,
  output logic [15:0]         taken_count
`endif
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, target;
  logic br_seen, capture;
  branch_target_calc #(.PC_WIDTH(PC_WIDTH)) u_target (
    .pc_plus2(pc_plus2),
    .imm8(imm8),
    .target(target)
  );
  // Anything arriving while busy is wrong-path and must not be captured or counted
  assign br_seen = valid_in & is_branch(opcode) & !stall & (state_q == ST_IDLE);
  assign capture = br_seen & taken;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pc_d = pc_q;
    if (capture) begin
      state_d = ST_REDIRECT;
      cnt_d = CW'(FLUSH_CYCLES - 1);
      pc_d = target;
    end else if (state_q == ST_REDIRECT) begin
      state_d = cnt_q != '0 ? ST_SQUASH : ST_IDLE;
    end else if (state_q == ST_SQUASH && !stall) begin
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? ST_IDLE : ST_SQUASH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
    end
  end
  assign redirect = state_q == ST_REDIRECT;
  assign redirect_pc = pc_q;
  assign busy = state_q != ST_IDLE;
  assign flush_if_id = busy;
  assign flush_id_ex = busy;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [15:0] br_count_q, br_count_d, taken_count_q, taken_count_d;
  always_comb begin
    br_count_d = br_seen && br_count_q != 16'hFFFF ? br_count_q + 16'd1 : br_count_q;
    taken_count_d = capture && taken_count_q != 16'hFFFF ? taken_count_q + 16'd1 : taken_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q <= '0;
      taken_count_q <= '0;
    end else begin
      br_count_q <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end
  assign br_count = br_count_q;
  assign taken_count = taken_count_q;
`endif
endmodule
